gate_controller: RTL and testbench

//  Entry-barrier controller for the parking system; sits directly upstream of the countdown timer.

---
 rtl/gate_controller.sv | 166 ++++++++++++++++
 tb/tb_gate_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_controller.sv
// gate_controller: entry-barrier controller for the parking lot.
// Debounces entry/pass/exit sensors, tracks occupancy, drives the gate.
//
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   entry_sensor   - raw: car waiting at the barrier
//   pass_sensor    - raw: beam behind the barrier broken
//   exit_sensor    - raw: car leaving at the exit lane
//   cd_value       - current value of the downstream countdown
//   cd_start       - one-cycle countdown start pulse
//   cd_time        - countdown load value (OPEN_TIME while cd_start)
//   gate_open      - barrier motor command
//   lot_full       - occupancy == CAPACITY
//   occupancy      - cars in the lot
//   timeout_err    - one-cycle pulse: closed by expiry, no pass seen
module gate_controller #(
  parameter int CAPACITY  = 100,
  parameter int OPEN_TIME = 30,
  parameter int DEBOUNCE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_sensor,
  input  logic       pass_sensor,
  input  logic       exit_sensor,
  input  logic [6:0] cd_value,
  output logic       cd_start,
  output logic [6:0] cd_time,
  output logic       gate_open,
  output logic       lot_full,
  output logic [7:0] occupancy,
  output logic       timeout_err
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);
  localparam logic [7:0] CAP = 8'(CAPACITY);
  localparam logic [6:0] OT  = 7'(OPEN_TIME);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OPEN  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CLOSE = 2'd3;

  // index 0 = entry, 1 = pass, 2 = exit
  logic [2:0]         raw;
  logic [2:0][CW-1:0] db_cnt_q;
  logic [2:0][CW-1:0] db_cnt_d;
  logic [2:0]         lvl_q;
  logic [2:0]         evt_q;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [1:0] guard_q;
  logic [1:0] guard_d;
  logic [7:0] occ_q;
  logic [7:0] occ_d;
  logic       tmo_q;
  logic       tmo_d;
  logic       inc;
  logic       ent_evt;
  logic       pas_evt;
  logic       ext_evt;

  assign raw = {exit_sensor, pass_sensor, entry_sensor};

  always_comb begin
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (!raw[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] != DB_MAX) begin
        db_cnt_d[i] = db_cnt_q[i] + CW'(1);
      end
    end
  end

  // Level follows the saturated counter one cycle later; the
  // event fires once per accepted level rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q <= '0;
      lvl_q    <= '0;
      evt_q    <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      for (int i = 0; i < 3; i++) begin
        lvl_q[i] <= (db_cnt_q[i] == DB_MAX);
        evt_q[i] <= (db_cnt_q[i] == DB_MAX) && !lvl_q[i];
      end
    end
  end

  assign ent_evt = evt_q[0];
  assign pas_evt = evt_q[1];
  assign ext_evt = evt_q[2];

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    tmo_d   = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ent_evt && !lot_full) begin
          state_d = S_OPEN;
        end
      end
      S_OPEN: begin
        guard_d = 2'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // guard hides cd_value while the countdown loads
        if (guard_q != 2'd2) begin
          guard_d = guard_q + 2'd1;
        end
        if (pas_evt) begin
          inc     = (occ_q < CAP);
          state_d = S_CLOSE;
        end else if (guard_q == 2'd2 && cd_value == 7'd0) begin
          tmo_d   = 1'b1;
          state_d = S_CLOSE;
        end
      end
      S_CLOSE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // a counted pass and an exit in the same cycle cancel out
  always_comb begin
    occ_d = occ_q;
    if (inc && !ext_evt) begin
      occ_d = occ_q + 8'd1;
    end else if (ext_evt && !inc && occ_q != 8'd0) begin
      occ_d = occ_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      guard_q <= 2'd0;
      occ_q   <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      occ_q   <= occ_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gate_open   = (state_q == S_OPEN) || (state_q == S_WAIT);
  assign cd_start    = (state_q == S_OPEN);
  assign cd_time     = cd_start ? OT : 7'd0;
  assign lot_full    = (occ_q == CAP);
  assign occupancy   = occ_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_gate_controller.sv
// tb_gate_controller: vector table, directed sequences and
// randomized traffic against a behavioural lot model.
module tb_gate_controller;

  localparam int CAP = 100;
  localparam int OT  = 30;
  localparam int DB  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_sensor;
  logic       pass_sensor;
  logic       exit_sensor;
  logic [6:0] cd_value;
  logic       cd_start;
  logic [6:0] cd_time;
  logic       gate_open;
  logic       lot_full;
  logic [7:0] occupancy;
  logic       timeout_err;

  always #5 clk = ~clk;

  gate_controller #(
    .CAPACITY (CAP),
    .OPEN_TIME(OT),
    .DEBOUNCE (DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entry_sensor(entry_sensor),
    .pass_sensor (pass_sensor),
    .exit_sensor (exit_sensor),
    .cd_value    (cd_value),
    .cd_start    (cd_start),
    .cd_time     (cd_time),
    .gate_open   (gate_open),
    .lot_full    (lot_full),
    .occupancy   (occupancy),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: lot occupancy, cycles since the gate started opening
  // (-1 = no car being served), one closing cycle, and the
  // consecutive-high run length of each raw sensor for the last
  // two edges (an event acts two edges after its run hits DB).
  int m_occ = 0;
  int m_since = -1;
  bit m_closing = 0;
  bit m_to = 0;
  int e_r1 = 0, e_r2 = 0;
  int p_r1 = 0, p_r2 = 0;
  int x_r1 = 0, x_r2 = 0;

  bit cd_auto = 0;
  int cdv = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int run_next(input logic r, input int n);
    return (r === 1'b1) ? n + 1 : 0;
  endfunction

  task automatic model_edge();
    bit ent, pas, ext, inc;
    if (reset === 1'b1) begin
      m_occ = 0; m_since = -1; m_closing = 0; m_to = 0;
      e_r1 = 0; e_r2 = 0; p_r1 = 0; p_r2 = 0;
      x_r1 = 0; x_r2 = 0;
      return;
    end
    ent = (e_r2 == DB);
    pas = (p_r2 == DB);
    ext = (x_r2 == DB);
    inc = 0;
    m_to = 0;
    if (m_closing) begin
      m_closing = 0;
    end else if (m_since < 0) begin
      if (ent && m_occ < CAP) m_since = 0;
    end else if (m_since == 0) begin
      m_since = 1;
    end else if (pas) begin
      inc = (m_occ < CAP);
      m_since = -1;
      m_closing = 1;
    end else if (m_since >= 3 && cd_value == 7'd0) begin
      m_to = 1;
      m_since = -1;
      m_closing = 1;
    end else begin
      m_since++;
    end
    if (inc && !ext) m_occ++;
    else if (ext && !inc && m_occ > 0) m_occ--;
    e_r2 = e_r1; e_r1 = run_next(entry_sensor, e_r1);
    p_r2 = p_r1; p_r1 = run_next(pass_sensor, p_r1);
    x_r2 = x_r1; x_r1 = run_next(exit_sensor, x_r1);
  endtask

  function automatic logic [31:0] exp_vec();
    bit g, s;
    g = (m_since >= 0);
    s = (m_since == 0);
    return {13'd0, g, s, s ? 7'(OT) : 7'd0,
            (m_occ == CAP), 8'(m_occ), m_to};
  endfunction

  function automatic logic [31:0] act_vec();
    return {13'd0, gate_open, cd_start, cd_time,
            lot_full, occupancy, timeout_err};
  endfunction

  task automatic step();
    logic st;
    st = cd_start;
    @(posedge clk);
    model_edge();
    #1;
    check("model", act_vec(), exp_vec());
    if (cd_auto) begin
      cdv = (st === 1'b1) ? OT : ((cdv > 0) ? cdv - 1 : 0);
      cd_value = 7'(cdv);
    end
  endtask

  task automatic hold(input bit e, input bit p, input bit x,
                      input int n);
    entry_sensor = e;
    pass_sensor = p;
    exit_sensor = x;
    repeat (n) step();
    entry_sensor = 0;
    pass_sensor = 0;
    exit_sensor = 0;
  endtask

  task automatic car_in();
    hold(1, 0, 0, DB);
    repeat (3) step();
    hold(0, 1, 0, DB);
    repeat (3) step();
  endtask

  typedef struct {
    bit         rst, ent, pas, ext;
    bit         gate, start;
    logic [6:0] ctime;
    logic [7:0] occ;
    bit         tmo;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit p, bit x, bit g,
                              bit s, int ct, int oc, bit t);
    vec_t v;
    v.rst = r; v.ent = e; v.pas = p; v.ext = x;
    v.gate = g; v.start = s; v.ctime = 7'(ct);
    v.occ = 8'(oc); v.tmo = t;
    return v;
  endfunction

  vec_t tbl[23];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int hl[3];
    bit lv[3];

    tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) tbl[i] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6] = mk(0, 0, 0, 0, 1, 1, OT, 0, 0);
    tbl[7] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 8; i <= 11; i++) tbl[i] = mk(0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 15; i <= 17; i++) tbl[i] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 18; i <= 22; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);

    reset = 1; entry_sensor = 0; pass_sensor = 0;
    exit_sensor = 0; cd_value = 7'd20;

    // open, pass, close; then a 3-cycle glitch
    for (int i = 0; i < 23; i++) begin
      reset = tbl[i].rst;
      entry_sensor = tbl[i].ent;
      pass_sensor = tbl[i].pas;
      exit_sensor = tbl[i].ext;
      step();
      check($sformatf("vec%0d", i), act_vec(),
            {13'd0, tbl[i].gate, tbl[i].start, tbl[i].ctime,
             1'b0, tbl[i].occ, tbl[i].tmo});
    end

    // countdown expiry with no pass
    cd_auto = 1; cdv = 0; cd_value = 7'd0;
    hold(1, 0, 0, DB);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (timeout_err === 1'b1) seen = 1;
    end
    check("timeout_seen", 32'(seen), 32'd1);
    check("timeout_gate", 32'(gate_open), 32'd0);
    check("timeout_occ", 32'(occupancy), 32'd1);
    step();
    check("timeout_pulse", 32'(timeout_err), 32'd0);

    // fill the lot
    repeat (CAP - 1) car_in();
    check("full_occ", 32'(occupancy), 32'(CAP));
    check("full_flag", 32'(lot_full), 32'd1);
    hold(1, 0, 0, DB);
    seen = 0;
    repeat (4) begin
      step();
      if (gate_open === 1'b1) seen = 1;
    end
    check("full_entry_ignored", 32'(seen), 32'd0);
    hold(0, 0, 1, DB);
    repeat (2) step();
    check("exit_occ", 32'(occupancy), 32'(CAP - 1));
    check("exit_notfull", 32'(lot_full), 32'd0);
    hold(1, 0, 0, DB);
    repeat (2) step();
    check("reopen_gate", 32'(gate_open), 32'd1);
    step();
    hold(0, 1, 0, DB);
    repeat (3) step();
    check("refill_occ", 32'(occupancy), 32'(CAP));

    // underflow and simultaneous pass/exit
    reset = 1; step(); reset = 0;
    check("rst_occ", 32'(occupancy), 32'd0);
    hold(0, 0, 1, DB);
    repeat (2) step();
    check("underflow", 32'(occupancy), 32'd0);
    repeat (5) car_in();
    check("five_cars", 32'(occupancy), 32'd5);
    hold(1, 0, 0, DB);
    repeat (3) step();
    hold(0, 1, 1, DB);
    repeat (3) step();
    check("pass_exit_occ", 32'(occupancy), 32'd5);
    check("pass_exit_gate", 32'(gate_open), 32'd0);

    // reset while waiting for the pass
    hold(1, 0, 0, DB);
    repeat (5) step();
    check("pre_rst_gate", 32'(gate_open), 32'd1);
    reset = 1; step(); reset = 0;
    check("mid_rst", {gate_open, occupancy, timeout_err}, 32'd0);
    seen = 0;
    repeat (40) begin
      step();
      if (timeout_err === 1'b1 || gate_open === 1'b1) seen = 1;
    end
    check("mid_rst_quiet", 32'(seen), 32'd0);

    // random traffic
    cd_auto = 0;
    for (int s = 0; s < 3; s++) begin
      hl[s] = 1; lv[s] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 3; s++) begin
        hl[s]--;
        if (hl[s] <= 0) begin
          lv[s] = !lv[s];
          hl[s] = $urandom_range(1, 7);
        end
      end
      entry_sensor = lv[0];
      pass_sensor = lv[1];
      exit_sensor = lv[2];
      cd_value = ($urandom_range(0, 3) == 0) ? 7'd0
                 : 7'($urandom_range(1, 127));
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
